// File: rtl/dnnweaver_ami_engine.sv
// Layer engine: streams each layer's 64-byte lines from AMI port0, applies a
// per-layer 16-bit-lane op and writes the result to AMI port1; free-running cycle counter.

`ifndef AMI_MACROS_DEFINED
`define AMI_MACROS_DEFINED
`define AMI_ADDR_WIDTH          64
`define AMI_DATA_WIDTH          512
`define AMI_REQ_SIZE_WIDTH      64
`define AMI_REQUEST_BUS_WIDTH   642
`define AMI_RESPONSE_BUS_WIDTH  577
`define AMIRequest_size         63:0
`define AMIRequest_data         575:64
`define AMIRequest_addr         639:576
`define AMIRequest_isWrite      640
`define AMIRequest_valid        641
`define AMIResponse_valid       0
`define AMIResponse_data        512:1
`define AMIResponse_size        576:513
`endif

module dnnweaver_ami_engine #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned ROM_ADDR_W    = 3,
  parameter int unsigned NUM_LAYERS    = 2,
  parameter int unsigned TX_SIZE_WIDTH = 20,
  parameter int unsigned LAYER_WORDS   = 4,
  parameter logic [ADDR_W-1:0] IN_BASE      = 32'h0,
  parameter logic [ADDR_W-1:0] LAYER_STRIDE = 32'h1000,
  parameter int unsigned D_TYPE_W      = 2,
  parameter logic [(2**ROM_ADDR_W)*D_TYPE_W-1:0] LAYER_DTYPES = 16'h0001
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                done,
  input  logic                                flush_buffer,
  output logic [`AMI_REQUEST_BUS_WIDTH-1:0]   mem_req0,
  input  logic                                mem_req0_grant,
  input  logic [`AMI_RESPONSE_BUS_WIDTH-1:0]  mem_resp0,
  output logic                                mem_resp0_grant,
  output logic [`AMI_REQUEST_BUS_WIDTH-1:0]   mem_req1,
  input  logic                                mem_req1_grant,
  input  logic [`AMI_RESPONSE_BUS_WIDTH-1:0]  mem_resp1,
  output logic                                mem_resp1_grant,
  output logic                                l_inc,
  output logic [63:0]                         cycle_count
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, NEXT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ROM_ADDR_W-1:0]    layer_q, layer_d;
  logic [TX_SIZE_WIDTH-1:0] line_q, line_d;
  logic [511:0]             data_q, data_d;
  logic                     linc_q, linc_d;
  logic [63:0]              cnt_q;

  logic [ADDR_W-1:0]   in_base, out_base, line_off;
  logic [D_TYPE_W-1:0] cur_op;
  logic                resp_valid;
  logic                unused_inputs;

  function automatic logic [15:0] lane_op(input logic [D_TYPE_W-1:0] op, input logic [15:0] x);
    logic [15:0] r;
    r = x;
    case (op)
      D_TYPE_W'(0): r = x;
      D_TYPE_W'(1): r = x[15] ? 16'h0000 : x;
      D_TYPE_W'(2): begin
        if (x[15] != x[14]) r = x[15] ? 16'h8000 : 16'h7FFF;
        else                r = {x[14:0], 1'b0};
      end
      default:      r = (x == 16'h8000) ? 16'h7FFF : (~x + 16'd1);
    endcase
    return r;
  endfunction

  function automatic logic [511:0] line_op(input logic [511:0] d, input logic [D_TYPE_W-1:0] op);
    logic [511:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[16*i +: 16] = lane_op(op, d[16*i +: 16]);
    return r;
  endfunction

  assign in_base    = IN_BASE + ADDR_W'(layer_q) * LAYER_STRIDE;
  assign out_base   = in_base + LAYER_STRIDE;
  assign line_off   = ADDR_W'(line_q) << 6;
  assign cur_op     = LAYER_DTYPES[layer_q*D_TYPE_W +: D_TYPE_W];
  assign resp_valid = mem_resp0[`AMIResponse_valid];

  assign unused_inputs = ^{mem_resp1, mem_resp0[`AMIResponse_size]};

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    line_d  = line_q;
    data_d  = data_q;
    linc_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RD_REQ;
        layer_d = '0;
        line_d  = '0;
      end
      RD_REQ:  if (mem_req0_grant) state_d = RD_WAIT;
      RD_WAIT: if (resp_valid) begin
        data_d  = line_op(mem_resp0[`AMIResponse_data], cur_op);
        state_d = WR_REQ;
      end
      WR_REQ:  if (mem_req1_grant) state_d = NEXT;
      NEXT: begin
        if (32'(line_q) < LAYER_WORDS - 1) begin
          line_d  = line_q + 1'b1;
          state_d = RD_REQ;
        end else begin
          linc_d = 1'b1;
          line_d = '0;
          if (32'(layer_q) < NUM_LAYERS - 1) begin
            layer_d = layer_q + 1'b1;
            state_d = RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over every transition above, including the layer-complete pulse.
    if (flush_buffer && state_q != IDLE) begin
      state_d = IDLE;
      layer_d = '0;
      line_d  = '0;
      linc_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      layer_q <= '0;
      line_q  <= '0;
      data_q  <= '0;
      linc_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      line_q  <= line_d;
      data_q  <= data_d;
      linc_q  <= linc_d;
      cnt_q   <= cnt_q + 64'd1;
    end
  end

  always_comb begin
    mem_req0 = '0;
    if (state_q == RD_REQ) begin
      mem_req0[`AMIRequest_valid]   = 1'b1;
      mem_req0[`AMIRequest_isWrite] = 1'b0;
      mem_req0[`AMIRequest_addr]    = `AMI_ADDR_WIDTH'(in_base + line_off);
      mem_req0[`AMIRequest_size]    = `AMI_REQ_SIZE_WIDTH'(64);
    end
  end

  always_comb begin
    mem_req1 = '0;
    if (state_q == WR_REQ) begin
      mem_req1[`AMIRequest_valid]   = 1'b1;
      mem_req1[`AMIRequest_isWrite] = 1'b1;
      mem_req1[`AMIRequest_addr]    = `AMI_ADDR_WIDTH'(out_base + line_off);
      mem_req1[`AMIRequest_data]    = data_q;
      mem_req1[`AMIRequest_size]    = `AMI_REQ_SIZE_WIDTH'(64);
    end
  end

  assign mem_resp0_grant = resp_valid && (state_q == RD_WAIT);
  assign mem_resp1_grant = 1'b1;
  assign done            = (state_q == DONE);
  assign l_inc           = linc_q;
  assign cycle_count     = cnt_q;

endmodule

// File: tb/tb_dnnweaver_ami_engine.sv
// Randomized bench: memory model with random grant/response latency, checked
// against a lane-arithmetic reference of the layer sequence.

`ifndef AMI_MACROS_DEFINED
`define AMI_MACROS_DEFINED
`define AMI_ADDR_WIDTH          64
`define AMI_DATA_WIDTH          512
`define AMI_REQ_SIZE_WIDTH      64
`define AMI_REQUEST_BUS_WIDTH   642
`define AMI_RESPONSE_BUS_WIDTH  577
`define AMIRequest_size         63:0
`define AMIRequest_data         575:64
`define AMIRequest_addr         639:576
`define AMIRequest_isWrite      640
`define AMIRequest_valid        641
`define AMIResponse_valid       0
`define AMIResponse_data        512:1
`define AMIResponse_size        576:513
`endif

module tb_dnnweaver_ami_engine;

  localparam int unsigned NL     = 4;
  localparam int unsigned LW     = 4;
  localparam logic [31:0] INB    = 32'h0;
  localparam logic [31:0] STRIDE = 32'h1000;
  localparam logic [15:0] DTYPES = 16'h001B;  // layer0 negate, 1 sat-shl, 2 relu, 3 pass

  logic clk, rst, start, flush, done, l_inc;
  logic [`AMI_REQUEST_BUS_WIDTH-1:0]  mem_req0, mem_req1;
  logic [`AMI_RESPONSE_BUS_WIDTH-1:0] mem_resp0, mem_resp1;
  logic mem_req0_grant, mem_req1_grant, mem_resp0_grant, mem_resp1_grant;
  logic [63:0] cycle_count;

  dnnweaver_ami_engine #(
    .NUM_LAYERS   (NL),
    .LAYER_WORDS  (LW),
    .IN_BASE      (INB),
    .LAYER_STRIDE (STRIDE),
    .LAYER_DTYPES (DTYPES)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .start           (start),
    .done            (done),
    .flush_buffer    (flush),
    .mem_req0        (mem_req0),
    .mem_req0_grant  (mem_req0_grant),
    .mem_resp0       (mem_resp0),
    .mem_resp0_grant (mem_resp0_grant),
    .mem_req1        (mem_req1),
    .mem_req1_grant  (mem_req1_grant),
    .mem_resp1       (mem_resp1),
    .mem_resp1_grant (mem_resp1_grant),
    .l_inc           (l_inc),
    .cycle_count     (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [511:0] mem     [logic [63:0]];
  logic [511:0] ref_mem [logic [63:0]];
  logic [63:0]  rd_q[$];
  logic [63:0]  wa_q[$];
  logic [511:0] wd_q[$];

  function automatic logic [15:0] ref_op(input int unsigned op, input logic [15:0] x);
    int v;
    int r;
    v = int'($signed(x));
    case (op)
      0:       r = v;
      1:       r = (v < 0) ? 0 : v;
      2:       r = v * 2;
      default: r = -v;
    endcase
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic build_expect();
    logic [63:0]  a_in, a_out;
    logic [511:0] d_in, d_out;
    ref_mem = mem;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    for (int k = 0; k < NL; k++) begin
      for (int j = 0; j < LW; j++) begin
        a_in  = 64'(INB) + 64'(k) * 64'(STRIDE) + 64'(j) * 64;
        a_out = a_in + 64'(STRIDE);
        d_in  = ref_mem.exists(a_in) ? ref_mem[a_in] : '0;
        for (int l = 0; l < 32; l++)
          d_out[16*l +: 16] = ref_op(int'(DTYPES[2*k +: 2]), d_in[16*l +: 16]);
        ref_mem[a_out] = d_out;
        rd_q.push_back(a_in);
        wa_q.push_back(a_out);
        wd_q.push_back(d_out);
      end
    end
  endtask

  // Memory model: variable grant delay, response 1..3 cycles after read grant.
  int unsigned  gd0, gd1, rlat;
  logic         rd_pending, resp_drv, hold_resp, p0_wait;
  logic [63:0]  raddr, p0_addr;
  int unsigned  linc_cnt;

  always @(negedge clk) begin
    if (rst) begin
      mem_req0_grant = 1'b0; mem_req1_grant = 1'b0;
      mem_resp0 = '0; rd_pending = 1'b0; resp_drv = 1'b0; p0_wait = 1'b0;
      gd0 = 0; gd1 = 0; rlat = 0; linc_cnt = 0;
    end else begin
      if (l_inc) linc_cnt++;
      if (mem_req0[`AMIRequest_valid] || mem_req1[`AMIRequest_valid])
        check_eq("rw_overlap", 512'(mem_req0[`AMIRequest_valid] & mem_req1[`AMIRequest_valid]), '0);
      if (resp_drv) begin
        resp_drv = 1'b0; rd_pending = 1'b0; mem_resp0 = '0;
      end else if (rd_pending && !hold_resp) begin
        if (rlat == 0) begin
          mem_resp0 = '0;
          mem_resp0[`AMIResponse_valid] = 1'b1;
          mem_resp0[`AMIResponse_data]  = mem.exists(raddr) ? mem[raddr] : '0;
          mem_resp0[`AMIResponse_size]  = 64'd64;
          resp_drv = 1'b1;
        end else rlat--;
      end
      if (p0_wait) begin
        check_eq("req0_hold_valid", 512'(mem_req0[`AMIRequest_valid]), 512'(1));
        check_eq("req0_hold_addr", 512'(mem_req0[`AMIRequest_addr]), 512'(p0_addr));
      end
      mem_req0_grant = 1'b0;
      p0_wait = 1'b0;
      if (mem_req0[`AMIRequest_valid]) begin
        if (gd0 == 0) begin
          mem_req0_grant = 1'b1;
          raddr = mem_req0[`AMIRequest_addr];
          check_eq("rd_iswrite", 512'(mem_req0[`AMIRequest_isWrite]), '0);
          check_eq("rd_size", 512'(mem_req0[`AMIRequest_size]), 512'(64));
          check_eq("rd_data0", 512'(mem_req0[`AMIRequest_data]), '0);
          if (rd_q.size() == 0) check_eq("rd_extra", 512'(raddr), '1);
          else check_eq("rd_addr", 512'(raddr), 512'(rd_q.pop_front()));
          rd_pending = 1'b1;
          rlat = $urandom_range(0, 2);
          gd0  = $urandom_range(0, 2);
        end else begin
          gd0--;
          p0_wait = 1'b1;
          p0_addr = mem_req0[`AMIRequest_addr];
        end
      end
      mem_req1_grant = 1'b0;
      if (mem_req1[`AMIRequest_valid]) begin
        if (gd1 == 0) begin
          mem_req1_grant = 1'b1;
          check_eq("wr_iswrite", 512'(mem_req1[`AMIRequest_isWrite]), 512'(1));
          check_eq("wr_size", 512'(mem_req1[`AMIRequest_size]), 512'(64));
          if (wa_q.size() == 0) check_eq("wr_extra", 512'(mem_req1[`AMIRequest_addr]), '1);
          else begin
            check_eq("wr_addr", 512'(mem_req1[`AMIRequest_addr]), 512'(wa_q.pop_front()));
            check_eq("wr_data", mem_req1[`AMIRequest_data], wd_q.pop_front());
          end
          mem[mem_req1[`AMIRequest_addr]] = mem_req1[`AMIRequest_data];
          gd1 = $urandom_range(0, 2);
        end else gd1--;
      end
    end
  end

  task automatic load_inputs();
    logic [511:0] line;
    for (int j = 0; j < LW; j++) begin
      for (int w = 0; w < 16; w++) line[32*w +: 32] = $urandom;
      if (j == 0) begin
        line[15:0]  = 16'h8000;
        line[31:16] = 16'hC000;
        line[47:32] = 16'h4000;
        line[63:48] = 16'h0001;
        line[79:64] = 16'hFFFF;
      end
      mem[64'(INB) + 64'(j) * 64] = line;
    end
  endtask

  task automatic do_run(input int unsigned first_delay);
    int unsigned cyc;
    load_inputs();
    build_expect();
    @(negedge clk); #1;
    linc_cnt = 0;
    gd0 = first_delay;
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check_eq("run_done", 512'(done), 512'(1));
    repeat (5) begin
      @(negedge clk); #1;
    end
    check_eq("done_held", 512'(done), 512'(1));
    check_eq("no_restart", 512'(mem_req0[`AMIRequest_valid]), '0);
    check_eq("linc_count", 512'(linc_cnt), 512'(NL));
    check_eq("rd_left", 512'(rd_q.size()), '0);
    check_eq("wr_left", 512'(wa_q.size()), '0);
    start = 1'b0;
    @(negedge clk); #1;
    check_eq("done_clear", 512'(done), '0);
  endtask

  initial begin
    int unsigned cyc;
    rst = 1'b1; start = 1'b0; flush = 1'b0; hold_resp = 1'b0;
    mem_resp1 = '0; mem_req0_grant = 1'b0; mem_req1_grant = 1'b0; mem_resp0 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", 512'(done), '0);
    check_eq("rst_cycles", 512'(cycle_count), '0);
    check_eq("rst_resp1_grant", 512'(mem_resp1_grant), 512'(1));
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("cycle_count_10", 512'(cycle_count), 512'(10));
    check_eq("idle_done", 512'(done), '0);
    check_eq("idle_v0", 512'(mem_req0[`AMIRequest_valid]), '0);
    check_eq("idle_v1", 512'(mem_req1[`AMIRequest_valid]), '0);
    check_eq("idle_linc", 512'(l_inc), '0);

    do_run(5);
    do_run(0);
    do_run($urandom_range(0, 3));

    // Abort during RD_WAIT; the late response must not be consumed.
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    rd_q.push_back(64'(INB));
    hold_resp = 1'b1;
    linc_cnt = 0;
    start = 1'b1;
    cyc = 0;
    while (!rd_pending && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    check_eq("flush_rd_issued", 512'(rd_pending), 512'(1));
    @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    flush = 1'b0;
    check_eq("flush_v0", 512'(mem_req0[`AMIRequest_valid]), '0);
    check_eq("flush_v1", 512'(mem_req1[`AMIRequest_valid]), '0);
    check_eq("flush_done", 512'(done), '0);
    hold_resp = 1'b0;
    cyc = 0;
    while (!mem_resp0[`AMIResponse_valid] && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    check_eq("late_resp_seen", 512'(mem_resp0[`AMIResponse_valid]), 512'(1));
    check_eq("late_resp_grant", 512'(mem_resp0_grant), '0);
    repeat (5) begin
      @(negedge clk); #1;
    end
    check_eq("flush_idle_v0", 512'(mem_req0[`AMIRequest_valid]), '0);
    check_eq("flush_no_linc", 512'(linc_cnt), '0);
    check_eq("flush_no_done", 512'(done), '0);

    do_run(1);

    // Reset mid-run restarts everything including the cycle counter.
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    load_inputs();
    build_expect();
    start = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_cycles", 512'(cycle_count), '0);
    check_eq("midrst_v0", 512'(mem_req0[`AMIRequest_valid]), '0);
    check_eq("midrst_v1", 512'(mem_req1[`AMIRequest_valid]), '0);
    check_eq("midrst_done", 512'(done), '0);
    check_eq("midrst_linc", 512'(l_inc), '0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
